// File: rtl/pic_bus_master_if.sv
// Bus bundle between the cycle generator and its command source / the PIC
// register port. The master modport is the cycle generator's view.
interface pic_bus_master_if;
    // Command side
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic       req_a0;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    // PIC register bus side
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a0;
    logic [7:0] d_out;
    logic       d_oe;
    logic [7:0] d_in;

    modport master (
        input  req_valid, req_write, req_a0, req_wdata, d_in,
        output req_ready, rsp_valid, rsp_rdata, busy,
               cs_n, rd_n, wr_n, a0, d_out, d_oe
    );

    modport slave (
        output req_valid, req_write, req_a0, req_wdata, d_in,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               cs_n, rd_n, wr_n, a0, d_out, d_oe
    );
endinterface

// File: rtl/pic_bus_master.sv
// Host-side 8086-style bus cycle generator for the PIC register port.
// One request per cycle: SETUP -> STROBE -> HOLD -> RECOVER, each phase
// lasting a parameterised number of clocks. All bus outputs are registered
// from the next-state decode so they change cleanly on clock edges.
module pic_bus_master #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 2,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pic_bus_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // Counter reload values: each phase lasts PARAM cycles, counting down to 0.
    localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYC - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       write_q, write_d;
    logic       a0_q, a0_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rsp_q, rsp_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       d_oe_q, d_oe_d;
    logic       cyc_active;

    // Next-state, counter and captured-data decode; bus outputs follow state_d.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        a0_d    = a0_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rsp_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    write_d = bus.req_write;
                    a0_d    = bus.req_a0;
                    wdata_d = bus.req_wdata;
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Sample the bus on the strobe's final edge, while rd_n is still low.
                    if (!write_q) begin
                        rdata_d = bus.d_in;
                    end
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LD;
                    rsp_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cyc_active = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        cs_n_d     = !cyc_active;
        rd_n_d     = !((state_d == STROBE) && !write_d);
        wr_n_d     = !((state_d == STROBE) && write_d);
        d_oe_d     = cyc_active && write_d;
    end

    // State, request capture and registered bus outputs; reset drops the bus at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            a0_q    <= 1'b0;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            rsp_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            d_oe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            a0_q    <= a0_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rsp_q   <= rsp_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            d_oe_q  <= d_oe_d;
        end
    end

    // a0 and d_out only change at acceptance, so they are stable for the whole cycle.
    assign bus.cs_n      = cs_n_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.a0        = a0_q;
    assign bus.d_out     = wdata_q;
    assign bus.d_oe      = d_oe_q;
    assign bus.rsp_valid = rsp_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.req_ready = (state_q == IDLE);
endmodule
